// File: rtl/me_search_sequencer.sv
// Full-search motion-estimation sequencer: walks a 16x16 block over a 31x31 window,
// driving R/S1/S2 ROM addresses, PE accumulator strobes and per-candidate results.
module me_search_sequencer #(
    parameter int unsigned BLK      = 16,
    parameter int unsigned RANGE    = 8,
    parameter int unsigned SSTRIDE  = 32,
    parameter int unsigned MEM_LAT  = 1,
    parameter int unsigned ACC_LAT  = 1,
    parameter int unsigned COMP_LAT = 1
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    output logic [7:0] AddressR,
    output logic [9:0] AddressS1,
    output logic [9:0] AddressS2,
    output logic       acc_clr,
    output logic       acc_en,
    output logic       dist_valid,
    output logic [3:0] cand_x1,
    output logic [3:0] cand_x2,
    output logic [3:0] cand_y,
    output logic       busy,
    output logic       completed
);

    localparam int unsigned H_W  = $clog2(BLK);
    localparam int unsigned P_W  = 2 * H_W;
    localparam int unsigned CX_W = $clog2(RANGE);
    localparam int unsigned CY_W = $clog2(2 * RANGE);
    localparam int unsigned PR_W = CY_W + CX_W;
    localparam int unsigned S_W  = PR_W + P_W;
    localparam int unsigned RC_W = CY_W + 1;
    localparam int unsigned CW_W = 12;

    localparam logic [S_W-1:0] STEP_LAST = '1;
    localparam logic [P_W-1:0] P_LAST    = '1;
    localparam logic [3:0]     Y_LAST    = 4'(RANGE - 1);
    localparam logic [3:0]     X1_LAST   = 4'(RANGE - 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    logic             start_q;
    logic [S_W-1:0]   step_q;
    logic             issue_v;

    logic [S_W-1:0]   step_nxt;
    logic [P_W-1:0]   p_n;
    logic [CX_W-1:0]  cx_n;
    logic [CY_W-1:0]  cy_n;
    logic [RC_W-1:0]  row_n;
    logic [RC_W-1:0]  col_n;
    logic [9:0]       s1_n;
    logic             start_rise;
    logic             fin_src;
    logic             fin_now;

    logic             m_v    [MEM_LAT];
    logic             m_clr  [MEM_LAT];
    logic             m_last [MEM_LAT];
    logic [PR_W-1:0]  m_pair [MEM_LAT];
    logic             d_v    [ACC_LAT];
    logic [CW_W-1:0]  d_cand [ACC_LAT];
    logic [CW_W-1:0]  cand_in;
    logic [CX_W-1:0]  m_cx;
    logic [CY_W-1:0]  m_cy;

    // Address of the step about to be issued, from offset-binary counters
    always_comb begin
        step_nxt = (state == RUN) ? step_q + S_W'(1) : '0;
        p_n      = step_nxt[P_W-1:0];
        cx_n     = step_nxt[P_W +: CX_W];
        cy_n     = step_nxt[P_W+CX_W +: CY_W];
        row_n    = RC_W'(p_n[P_W-1:H_W]) + RC_W'(cy_n);
        col_n    = RC_W'(p_n[H_W-1:0]) + RC_W'({cx_n, 1'b0});
        s1_n     = 10'(32'(row_n) * SSTRIDE + 32'(col_n));
    end

    assign start_rise = start && !start_q;

    // Sequencer FSM and address registers
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= IDLE;
            start_q   <= 1'b1;
            step_q    <= '0;
            issue_v   <= 1'b0;
            AddressR  <= '0;
            AddressS1 <= '0;
            AddressS2 <= '0;
            busy      <= 1'b0;
            completed <= 1'b0;
        end else begin
            start_q <= start;
            case (state)
                IDLE, DONE: begin
                    if (start_rise) begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        completed <= 1'b0;
                        issue_v   <= 1'b1;
                        step_q    <= '0;
                        AddressR  <= 8'(p_n);
                        AddressS1 <= s1_n;
                        AddressS2 <= s1_n + 10'd1;
                    end
                end
                RUN: begin
                    if (step_q == STEP_LAST) begin
                        state   <= DRAIN;
                        issue_v <= 1'b0;
                    end else begin
                        step_q    <= step_nxt;
                        AddressR  <= 8'(p_n);
                        AddressS1 <= s1_n;
                        AddressS2 <= s1_n + 10'd1;
                    end
                end
                DRAIN: begin
                    if (fin_now) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        completed <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Candidate vector in two's complement; S2 offset is always the odd neighbour
    always_comb begin
        m_cx    = m_pair[MEM_LAT-1][CX_W-1:0];
        m_cy    = m_pair[MEM_LAT-1][PR_W-1:CX_W];
        cand_in = {4'(m_cy) ^ 4'b1000,
                   4'({m_cx, 1'b1}) ^ 4'b1000,
                   4'({m_cx, 1'b0}) ^ 4'b1000};
    end

    // ROM-latency and accumulator-latency alignment pipelines
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int n = 0; n < int'(MEM_LAT); n++) begin
                m_v[n]    <= 1'b0;
                m_clr[n]  <= 1'b0;
                m_last[n] <= 1'b0;
                m_pair[n] <= '0;
            end
            for (int n = 0; n < int'(ACC_LAT); n++) begin
                d_v[n]    <= 1'b0;
                d_cand[n] <= '0;
            end
        end else begin
            m_v[0]    <= issue_v;
            m_clr[0]  <= issue_v && (step_q[P_W-1:0] == '0);
            m_last[0] <= issue_v && (step_q[P_W-1:0] == P_LAST);
            m_pair[0] <= step_q[S_W-1:P_W];
            for (int n = 1; n < int'(MEM_LAT); n++) begin
                m_v[n]    <= m_v[n-1];
                m_clr[n]  <= m_clr[n-1];
                m_last[n] <= m_last[n-1];
                m_pair[n] <= m_pair[n-1];
            end
            d_v[0] <= m_last[MEM_LAT-1];
            if (m_last[MEM_LAT-1]) begin
                d_cand[0] <= cand_in;
            end
            for (int n = 1; n < int'(ACC_LAT); n++) begin
                d_v[n] <= d_v[n-1];
                if (d_v[n-1]) begin
                    d_cand[n] <= d_cand[n-1];
                end
            end
        end
    end

    assign acc_en     = m_v[MEM_LAT-1];
    assign acc_clr    = m_clr[MEM_LAT-1];
    assign dist_valid = d_v[ACC_LAT-1];
    assign cand_x1    = d_cand[ACC_LAT-1][3:0];
    assign cand_x2    = d_cand[ACC_LAT-1][7:4];
    assign cand_y     = d_cand[ACC_LAT-1][11:8];

    assign fin_src = dist_valid && (cand_y == Y_LAST) && (cand_x1 == X1_LAST);

    // Completion delay: fin_now fires the cycle before completed must be seen high
    if (COMP_LAT == 1) begin : g_fin_direct
        assign fin_now = fin_src;
    end else begin : g_fin_pipe
        logic f_q [COMP_LAT-1];
        always_ff @(posedge clock) begin
            if (!reset_n) begin
                for (int n = 0; n < int'(COMP_LAT) - 1; n++) begin
                    f_q[n] <= 1'b0;
                end
            end else begin
                f_q[0] <= fin_src;
                for (int n = 1; n < int'(COMP_LAT) - 1; n++) begin
                    f_q[n] <= f_q[n-1];
                end
            end
        end
        assign fin_now = f_q[COMP_LAT-2];
    end

endmodule

// File: tb/tb_me_search_sequencer.sv
// Randomized bench for me_search_sequencer: a cycle-indexed behavioural model of the
// search predicts every output, checked each falling edge.
module tb_me_search_sequencer;

    localparam int M      = 1;
    localparam int A      = 1;
    localparam int C      = 1;
    localparam int STEPS  = 32768;
    localparam int END_N  = STEPS - 1 + M + A + C;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       start;
    logic [7:0] AddressR;
    logic [9:0] AddressS1;
    logic [9:0] AddressS2;
    logic       acc_clr;
    logic       acc_en;
    logic       dist_valid;
    logic [3:0] cand_x1;
    logic [3:0] cand_x2;
    logic [3:0] cand_y;
    logic       busy;
    logic       completed;

    always #5 clock = ~clock;

    me_search_sequencer dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .AddressR   (AddressR),
        .AddressS1  (AddressS1),
        .AddressS2  (AddressS2),
        .acc_clr    (acc_clr),
        .acc_en     (acc_en),
        .dist_valid (dist_valid),
        .cand_x1    (cand_x1),
        .cand_x2    (cand_x2),
        .cand_y     (cand_y),
        .busy       (busy),
        .completed  (completed)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s at t=%0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // Model state: m_n counts rising edges since the start-detect edge
    bit m_active = 1'b0;
    bit m_done   = 1'b0;
    bit m_prev   = 1'b1;
    bit m_rst    = 1'b0;
    int m_n      = -1;

    always @(posedge clock) begin
        if (!reset_n) begin
            m_active = 1'b0;
            m_done   = 1'b0;
            m_prev   = 1'b1;
            m_rst    = 1'b1;
            m_n      = -1;
        end else begin
            m_rst = 1'b0;
            if (m_active) begin
                m_n++;
                if (m_n == END_N) begin
                    m_active = 1'b0;
                    m_done   = 1'b1;
                end
            end else if (start && !m_prev) begin
                m_active = 1'b1;
                m_done   = 1'b0;
                m_n      = 0;
            end
            m_prev = start;
        end
    end

    function automatic int s1_of(input int k);
        int i    = (k % 256) / 16;
        int j    = k % 16;
        int pair = k / 256;
        int mx   = 2 * (pair % 8) - 8;
        int my   = pair / 8 - 8;
        return (i + my + 8) * 32 + (j + mx + 8);
    endfunction

    int dv_cnt      = 0;
    int acc_cnt     = 0;
    bit cnt_pending = 1'b0;

    always @(negedge clock) begin
        bit e_acc;
        bit e_clr;
        bit e_dv;
        int pair;
        if (m_rst) begin
            cnt_pending = 1'b0;
            chk("rst_addr_r",  32'(AddressR),   0);
            chk("rst_addr_s1", 32'(AddressS1),  0);
            chk("rst_addr_s2", 32'(AddressS2),  0);
            chk("rst_acc_clr", 32'(acc_clr),    0);
            chk("rst_acc_en",  32'(acc_en),     0);
            chk("rst_dv",      32'(dist_valid), 0);
            chk("rst_x1",      32'(cand_x1),    0);
            chk("rst_x2",      32'(cand_x2),    0);
            chk("rst_y",       32'(cand_y),     0);
            chk("rst_busy",    32'(busy),       0);
            chk("rst_done",    32'(completed),  0);
        end else begin
            e_acc = m_active && m_n >= M && m_n <= STEPS - 1 + M;
            e_clr = e_acc && ((m_n - M) % 256 == 0);
            e_dv  = m_active && m_n >= M + A && m_n <= STEPS - 1 + M + A
                    && ((m_n - M - A) % 256 == 255);
            chk("acc_en",     32'(acc_en),     32'(e_acc));
            chk("acc_clr",    32'(acc_clr),    32'(e_clr));
            chk("dist_valid", 32'(dist_valid), 32'(e_dv));
            chk("busy",       32'(busy),       32'(m_active));
            chk("completed",  32'(completed),  32'(m_done));
            if (m_active && m_n <= STEPS - 1) begin
                chk("addr_r",  32'(AddressR),  m_n % 256);
                chk("addr_s1", 32'(AddressS1), s1_of(m_n));
                chk("addr_s2", 32'(AddressS2), s1_of(m_n) + 1);
            end
            if (e_dv) begin
                pair = (m_n - M - A) / 256;
                chk("cand_x1", 32'($signed(cand_x1)), 2 * (pair % 8) - 8);
                chk("cand_x2", 32'($signed(cand_x2)), 2 * (pair % 8) - 7);
                chk("cand_y",  32'($signed(cand_y)),  pair / 8 - 8);
            end
            // Hand-computed anchors for the model itself
            if (m_active && m_n == 0) begin
                chk("lit_r_first",  32'(AddressR),  0);
                chk("lit_s1_first", 32'(AddressS1), 0);
                chk("lit_s2_first", 32'(AddressS2), 1);
            end
            if (m_active && m_n == 17) begin
                chk("lit_r_17",  32'(AddressR),  17);
                chk("lit_s1_17", 32'(AddressS1), 33);
                chk("lit_s2_17", 32'(AddressS2), 34);
            end
            if (m_active && m_n == 256) begin
                chk("lit_s1_pair2", 32'(AddressS1), 2);
                chk("lit_s2_pair2", 32'(AddressS2), 3);
            end
            if (m_active && m_n == STEPS - 1) begin
                chk("lit_r_last",  32'(AddressR),  255);
                chk("lit_s1_last", 32'(AddressS1), 989);
                chk("lit_s2_last", 32'(AddressS2), 990);
            end
            if (m_active && m_n == M + A + 255) begin
                chk("lit_x1_first", 32'($signed(cand_x1)), -8);
                chk("lit_x2_first", 32'($signed(cand_x2)), -7);
                chk("lit_y_first",  32'($signed(cand_y)),  -8);
            end
            if (m_active && m_n == STEPS - 1 + M + A) begin
                chk("lit_x1_last", 32'($signed(cand_x1)), 6);
                chk("lit_x2_last", 32'($signed(cand_x2)), 7);
                chk("lit_y_last",  32'($signed(cand_y)),  7);
            end
            if (m_active && m_n == 0) begin
                dv_cnt      = 0;
                acc_cnt     = 0;
                cnt_pending = 1'b1;
            end
            if (dist_valid === 1'b1) dv_cnt++;
            if (acc_en === 1'b1) acc_cnt++;
            if (m_done && cnt_pending) begin
                chk("dv_count",  dv_cnt,  128);
                chk("acc_count", acc_cnt, STEPS);
                cnt_pending = 1'b0;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_done(input string nm);
        int b = 0;
        while (completed !== 1'b1 && b < 34000) begin
            @(negedge clock);
            b++;
        end
        chk(nm, 32'(completed), 1);
    endtask

    initial begin
        int b;
        reset_n = 1'b0;
        start   = 1'b0;
        cyc(3);
        reset_n = 1'b1;
        cyc(2);
        start = 1'b1;
        wait_done("run1_done");
        cyc(20);

        start = 1'b0;
        cyc($urandom_range(1, 3));
        start = 1'b1;
        b = 0;
        while (m_n != 5000 && b < 6000) begin
            @(negedge clock);
            b++;
        end
        chk("reach_step_5000", m_n, 5000);
        reset_n = 1'b0;
        cyc(1);
        reset_n = 1'b1;
        cyc(10);
        start = 1'b0;
        cyc(2);
        start = 1'b1;
        cyc(1);

        for (int t = 0; t < 30000; t++) begin
            if ($urandom_range(0, 99) == 0) start = ~start;
            cyc(1);
        end
        start = 1'b1;
        wait_done("run3_done");
        cyc(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
